// File: rtl/apu_reg_sequencer.sv
// apu_reg_sequencer: pairs UART data/address bytes into APU register writes,
// queues them in a small FIFO, and issues at most one write per apu_ce.
// Optional feature macro: CMD_TIMEOUT_EN (drops a stale data byte after
// TIMEOUT_CYCLES idle cycles in HAVE_DATA).
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; every byte
// presented with rx_valid=1 is consumed that cycle. apu_ce is a qualifier only:
// a queued write is popped in a cycle where apu_ce=1 and appears on reg_we in
// the following cycle. There is no ready signal in either direction.
module apu_reg_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       apu_ce,
    output logic       reg_we,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       err_seq,
    output logic       overflow,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE      = 1'b0,
        HAVE_DATA = 1'b1
    } state_t;

    state_t     state_q, state_next;
    logic [6:0] data_q, data_next;
    logic       push, pop, err_next;

    logic [4:0]    fifo_addr [DEPTH];
    logic [7:0]    fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, push_ok;

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && apu_ce;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);
    assign busy       = !fifo_empty || (state_q != IDLE);

`ifdef CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    assign timeout_hit = (state_q == HAVE_DATA) && !rx_valid &&
                         (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter: runs only while a data byte waits for its address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_q != HAVE_DATA || rx_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    // State and latched data byte register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_next;
            data_q  <= data_next;
        end
    end

    // Byte-pairing decode: next state, data latch, push request and error.
    always_comb begin
        state_next = state_q;
        data_next  = data_q;
        push       = 1'b0;
        err_next   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[7]) begin
                        err_next = 1'b1;
                    end else begin
                        data_next  = rx_data[6:0];
                        state_next = HAVE_DATA;
                    end
                end
            end
            HAVE_DATA: begin
                if (rx_valid) begin
                    if (!rx_data[7]) begin
                        data_next = rx_data[6:0];
                        err_next  = 1'b1;
                    end else if (rx_data[6]) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= rx_data[5:1];
            fifo_data[wr_ptr] <= {rx_data[0], data_q};
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            if (push && !push_ok)     overflow <= 1'b1;
        end
    end

    // Registered write port and error pulse; addr/data hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
            err_seq  <= 1'b0;
        end else begin
            reg_we  <= pop;
            err_seq <= err_next;
            if (pop) begin
                reg_addr <= fifo_addr[rd_ptr];
                reg_data <= fifo_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_apu_reg_sequencer.sv
// tb_apu_reg_sequencer: directed table-driven bench for apu_reg_sequencer.
// Also exercises CMD_TIMEOUT_EN behaviour when that macro is defined.
module tb_apu_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       apu_ce = 1'b0;
    logic       reg_we;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       err_seq;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int ce_mode = 0;   // 0: apu_ce always high, 1: every 4th clk, 2: held low
    logic [12:0] got_q[$];
    logic [12:0] exp_q[$];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n_we;
        logic [12:0] wr;
        int          n_err;
    } vec_t;

    vec_t vecs[6];

    apu_reg_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .apu_ce   (apu_ce),
        .reg_we   (reg_we),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .err_seq  (err_seq),
        .overflow (overflow),
        .busy     (busy)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // apu_ce pattern generator
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            case (ce_mode)
                0:       apu_ce = 1'b1;
                1:       apu_ce = (div == 0);
                default: apu_ce = 1'b0;
            endcase
        end
    end

    // Monitor: record writes and error pulses away from the active edge
    always @(negedge clk) begin
        if (reg_we === 1'b1) got_q.push_back({reg_addr, reg_data});
        if (err_seq === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    // Scoreboard compare of recorded writes against the expected queue
    task automatic compare_writes(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_wr"}, got_q[i], exp_q[i]);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_we"},   reg_we,   1'b0);
        check({name, "_addr"}, reg_addr, 5'd0);
        check({name, "_data"}, reg_data, 8'd0);
        check({name, "_err"},  err_seq,  1'b0);
        check({name, "_ovf"},  overflow, 1'b0);
        check({name, "_busy"}, busy,     1'b0);
    endtask

    initial begin
        vecs[0] = '{b0: 8'h27, b1: 8'h83, n_we: 1, wr: {5'd1,  8'hA7}, n_err: 0};
        vecs[1] = '{b0: 8'h7F, b1: 8'hBF, n_we: 1, wr: {5'd31, 8'hFF}, n_err: 0};
        vecs[2] = '{b0: 8'h00, b1: 8'h80, n_we: 1, wr: {5'd0,  8'h00}, n_err: 0};
        vecs[3] = '{b0: 8'h01, b1: 8'hA0, n_we: 1, wr: {5'd16, 8'h01}, n_err: 0};
        vecs[4] = '{b0: 8'h55, b1: 8'hC2, n_we: 0, wr: 13'd0,          n_err: 1};
        vecs[5] = '{b0: 8'h84, b1: 8'h84, n_we: 0, wr: 13'd0,          n_err: 2};

        // Reset state
        wait_clk(3);
        rst_n = 1'b1;
        #1;
        check_outputs_zero("reset");

        // Table-driven single pairs, apu_ce always high
        ce_mode = 0;
        for (int v = 0; v < 6; v++) begin
            clear_obs();
            send_byte(vecs[v].b0);
            send_byte(vecs[v].b1);
            wait_clk(8);
            if (vecs[v].n_we != 0) exp_q.push_back(vecs[v].wr);
            compare_writes($sformatf("vec%0d", v));
            check($sformatf("vec%0d_err", v), err_cnt, vecs[v].n_err);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
        end

        // Test 1: apu_ce every 4 clk, exactly one write
        clear_obs();
        ce_mode = 1;
        send_byte(8'h27);
        send_byte(8'h83);
        wait_clk(16);
        exp_q.push_back({5'd1, 8'hA7});
        compare_writes("ce4");
        check("ce4_err", err_cnt, 0);

        // Test 2: four back-to-back pairs in order
        clear_obs();
        ce_mode = 0;
        send_byte(8'h27); send_byte(8'h83);
        send_byte(8'h02); send_byte(8'h81);
        send_byte(8'h7C); send_byte(8'h84);
        send_byte(8'h09); send_byte(8'h86);
        wait_clk(10);
        exp_q.push_back({5'd1, 8'hA7});
        exp_q.push_back({5'd0, 8'h82});
        exp_q.push_back({5'd2, 8'h7C});
        exp_q.push_back({5'd3, 8'h09});
        compare_writes("stream");
        check("stream_busy", busy, 1'b0);
        check("stream_err", err_cnt, 0);

        // Test 3: orphan address, then data replaced before its address
        clear_obs();
        send_byte(8'h84);
        wait_clk(5);
        check("orphan_err", err_cnt, 1);
        compare_writes("orphan");
        clear_obs();
        send_byte(8'h13);
        send_byte(8'h1E);
        send_byte(8'h81);
        wait_clk(6);
        exp_q.push_back({5'd0, 8'h9E});
        compare_writes("replace");
        check("replace_err", err_cnt, 1);

        // Test 4: five pairs while apu_ce low overflow a 4-entry FIFO
        clear_obs();
        ce_mode = 2;
        wait_clk(2);
        for (int k = 1; k <= 5; k++) begin
            logic [7:0] a;
            a = 8'h80 | 8'(k << 1);
            send_byte(8'(k));
            send_byte(a);
        end
        wait_clk(3);
        check("ovf_set", overflow, 1'b1);
        check("ovf_nowrite", got_q.size(), 0);
        check("ovf_busy", busy, 1'b1);
        ce_mode = 0;
        wait_clk(12);
        for (int k = 1; k <= 4; k++) exp_q.push_back({5'(k), 8'(k)});
        compare_writes("ovf_drain");
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_busy_done", busy, 1'b0);

        // Test 5: stale data byte with long idle gap
        pulse_reset();
        clear_obs();
        send_byte(8'h4B);
`ifdef CMD_TIMEOUT_EN
        wait_clk(25000 + 10);
        check("tmo_err", err_cnt, 1);
        send_byte(8'h83);
        wait_clk(6);
        check("tmo_orphan_err", err_cnt, 2);
        compare_writes("tmo");
`else
        wait_clk(200);
        check("tmo_err", err_cnt, 0);
        send_byte(8'h83);
        wait_clk(6);
        exp_q.push_back({5'd1, 8'hCB});
        compare_writes("notmo");
        check("notmo_err", err_cnt, 0);
`endif

        // Test 6: reset between data and address discards the data byte
        clear_obs();
        send_byte(8'h27);
        pulse_reset();
        check_outputs_zero("midreset");
        send_byte(8'h83);
        wait_clk(6);
        check("midreset_err", err_cnt, 1);
        compare_writes("midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
